// File: rtl/cmd_seq_pkg.sv
// Shared definitions for the command sequencer: bus register map, memory
// base offset, serializer FSM encoding and the configuration bundle handed
// from the register block to the serializer.
package cmd_seq_pkg;

  localparam logic [15:0] A_SOFT_RST = 16'd0;
  localparam logic [15:0] A_START    = 16'd1;
  localparam logic [15:0] A_CONF     = 16'd2;
  localparam logic [15:0] A_SIZE_LO  = 16'd3;
  localparam logic [15:0] A_SIZE_HI  = 16'd4;
  localparam logic [15:0] A_REP_LO   = 16'd5;
  localparam logic [15:0] A_REP_HI   = 16'd6;
  localparam logic [15:0] A_GAP_LO   = 16'd7;
  localparam logic [15:0] A_GAP_HI   = 16'd8;
  localparam logic [15:0] A_MASK     = 16'd9;
  localparam logic [15:0] A_ABORT    = 16'd10;
  localparam logic [15:0] MEM_BASE   = 16'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } ser_state_e;

  typedef struct packed {
    logic [15:0] size;  // bits per repetition
    logic [15:0] rep;   // repetitions, 0 = endless
    logic [15:0] gap;   // idle cycles between repetitions
  } seq_cfg_t;

endpackage

// File: rtl/cmd_seq_mc_if.sv
// Byte-wide register/memory bus of the command sequencer.
//   BUS_ADD      : 16-bit address
//   BUS_DATA_IN  : write data
//   BUS_RD/WR    : read / write strobes
//   BUS_DATA_OUT : read data, one cycle after the address is sampled
interface cmd_seq_mc_if;
  logic [15:0] BUS_ADD;
  logic [7:0]  BUS_DATA_IN;
  logic        BUS_RD;
  logic        BUS_WR;
  logic [7:0]  BUS_DATA_OUT;

  modport master (output BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR, input BUS_DATA_OUT);
  modport slave  (input BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR, output BUS_DATA_OUT);
endinterface

// File: rtl/cmd_seq_ser.sv
// Serializer: IDLE/SEND/GAP FSM, bit counter, repetition and gap counters
// and the byte shift register. Reads command memory combinationally one byte
// at a time and shifts it out MSB first, one bit per clock.
//   clk, rst        : clock, synchronous active-high reset
//   start, abort    : single-cycle requests from the bus/trigger logic
//   cfg, mask       : live register values, latched when a start is taken
//   mem_addr/byte   : command memory read port
//   cmd_data        : registered serial outputs (bit AND latched mask)
//   ready           : state == IDLE
//   rep_strobe      : registered, coincides with first bit of a repetition
module cmd_seq_ser
  import cmd_seq_pkg::*;
#(
  parameter int MEM_BYTES = 2048,
  parameter int OUT_LINES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  seq_cfg_t                     cfg,
  input  logic [OUT_LINES-1:0]         mask,
  output logic [$clog2(MEM_BYTES)-1:0] mem_addr,
  input  logic [7:0]                   mem_byte,
  output logic [OUT_LINES-1:0]         cmd_data,
  output logic                         ready,
  output logic                         rep_strobe
);
  localparam int          BW       = $clog2(MEM_BYTES) + 3;
  localparam logic [15:0] MAX_BITS = 16'(MEM_BYTES * 8);

  ser_state_e           state, state_n;
  logic [15:0]          rep_lat, gap_lat, rep_done, gap_cnt, size_sat;
  logic [OUT_LINES-1:0] mask_lat;
  logic [BW-1:0]        bit_cnt, last_idx;
  logic [7:0]           shreg;
  logic                 last_bit, rep_end, gap_end, cur_bit;

  assign size_sat = (cfg.size > MAX_BITS) ? MAX_BITS : cfg.size;
  assign mem_addr = bit_cnt[BW-1:3];
  assign ready    = (state == ST_IDLE);
  assign last_bit = (bit_cnt == last_idx);
  // rep_lat == 0 never terminates; rep_done is allowed to wrap then
  assign rep_end  = (rep_lat != 16'd0) && (rep_done + 16'd1 == rep_lat);
  assign gap_end  = (gap_cnt + 16'd1 == gap_lat);
  // first bit of each byte comes straight from memory, the rest from shreg
  assign cur_bit  = (bit_cnt[2:0] == 3'd0) ? mem_byte[7] : shreg[7];

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start && size_sat != 16'd0) state_n = ST_SEND;
      ST_SEND: begin
        if (abort)                state_n = ST_IDLE;
        else if (last_bit) begin
          if (rep_end)            state_n = ST_IDLE;
          else if (gap_lat != 0)  state_n = ST_GAP;
        end
      end
      ST_GAP: begin
        if (abort)                state_n = ST_IDLE;
        else if (gap_end)         state_n = ST_SEND;
      end
      default:                    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd_data   <= '0;
      rep_strobe <= 1'b0;
      bit_cnt    <= '0;
      last_idx   <= '0;
      rep_lat    <= '0;
      gap_lat    <= '0;
      rep_done   <= '0;
      gap_cnt    <= '0;
      mask_lat   <= '0;
      shreg      <= '0;
    end else begin
      state      <= state_n;
      cmd_data   <= '0;
      rep_strobe <= 1'b0;
      case (state)
        ST_IDLE: if (state_n == ST_SEND) begin
          last_idx <= BW'(size_sat - 16'd1);
          rep_lat  <= cfg.rep;
          gap_lat  <= cfg.gap;
          mask_lat <= mask;
          bit_cnt  <= '0;
          rep_done <= '0;
        end
        ST_SEND: if (!abort) begin
          cmd_data   <= {OUT_LINES{cur_bit}} & mask_lat;
          rep_strobe <= (bit_cnt == '0);
          shreg      <= (bit_cnt[2:0] == 3'd0) ? {mem_byte[6:0], 1'b0} : {shreg[6:0], 1'b0};
          if (last_bit) begin
            bit_cnt  <= '0;
            rep_done <= rep_done + 16'd1;
            gap_cnt  <= '0;
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        ST_GAP:  gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/cmd_seq_mc.sv
// Command sequencer top: bus register block, command memory, bus read mux,
// external trigger synchroniser, and the serializer instance.
//   BUS_CLK, BUS_RST : clock, synchronous active-high reset
//   bus              : register/memory bus (slave side)
//   CMD_EXT_START    : asynchronous external trigger
//   CMD_DATA         : serial command bit per line
//   CMD_READY        : high while idle
//   CMD_REP_STROBE   : pulse with the first bit of each repetition
module cmd_seq_mc
  import cmd_seq_pkg::*;
#(
  parameter int MEM_BYTES = 2048,
  parameter int OUT_LINES = 4
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  cmd_seq_mc_if.slave          bus,
  input  logic                 CMD_EXT_START,
  output logic [OUT_LINES-1:0] CMD_DATA,
  output logic                 CMD_READY,
  output logic                 CMD_REP_STROBE
);
  localparam int          AW      = $clog2(MEM_BYTES);
  localparam logic [15:0] MEM_END = MEM_BASE + 16'(MEM_BYTES);

  logic [2:0]           conf;  // {ABORT_EN, EXT_NEGEDGE, EXT_START_EN}
  logic [15:0]          cmd_size, rep_count, rep_gap;
  logic [OUT_LINES-1:0] out_mask;
  logic [7:0]           mem [MEM_BYTES];
  logic                 soft_rst, rst_all, in_mem, start, abort;
  logic                 ext_s0, ext_s1, ext_s2, ext_edge;
  logic [AW-1:0]        mem_idx, ser_addr;
  logic [7:0]           ser_byte, rd_mux, mask_rd;
  seq_cfg_t             cfg;

  assign soft_rst = bus.BUS_WR && (bus.BUS_ADD == A_SOFT_RST);
  assign rst_all  = BUS_RST || soft_rst;
  assign in_mem   = (bus.BUS_ADD >= MEM_BASE) && (bus.BUS_ADD < MEM_END);
  assign mem_idx  = AW'(bus.BUS_ADD - MEM_BASE);

  // two-flop synchroniser plus one history flop for edge detection; left
  // unreset so a reset cannot fabricate a trigger edge
  always_ff @(posedge BUS_CLK) begin
    ext_s0 <= CMD_EXT_START;
    ext_s1 <= ext_s0;
    ext_s2 <= ext_s1;
  end

  assign ext_edge = conf[1] ? (ext_s2 & ~ext_s1) : (ext_s1 & ~ext_s2);
  // the serializer only honours start in IDLE and abort while busy, so one
  // trigger edge may feed both
  assign start = (bus.BUS_WR && bus.BUS_ADD == A_START) || (conf[0] && ext_edge);
  assign abort = (bus.BUS_WR && bus.BUS_ADD == A_ABORT) || (conf[2] && ext_edge);

  always_ff @(posedge BUS_CLK) begin
    if (rst_all) begin
      conf      <= '0;
      cmd_size  <= '0;
      rep_count <= 16'd1;
      rep_gap   <= '0;
      out_mask  <= '1;
    end else if (bus.BUS_WR) begin
      case (bus.BUS_ADD)
        A_CONF:    conf            <= bus.BUS_DATA_IN[2:0];
        A_SIZE_LO: cmd_size[7:0]   <= bus.BUS_DATA_IN;
        A_SIZE_HI: cmd_size[15:8]  <= bus.BUS_DATA_IN;
        A_REP_LO:  rep_count[7:0]  <= bus.BUS_DATA_IN;
        A_REP_HI:  rep_count[15:8] <= bus.BUS_DATA_IN;
        A_GAP_LO:  rep_gap[7:0]    <= bus.BUS_DATA_IN;
        A_GAP_HI:  rep_gap[15:8]   <= bus.BUS_DATA_IN;
        A_MASK:    out_mask        <= bus.BUS_DATA_IN[OUT_LINES-1:0];
        default: ;
      endcase
    end
  end

  // memory is deliberately outside the reset domain
  always_ff @(posedge BUS_CLK) begin
    if (bus.BUS_WR && in_mem) mem[mem_idx] <= bus.BUS_DATA_IN;
  end

  assign ser_byte = mem[ser_addr];

  always_comb begin
    mask_rd                = '0;
    mask_rd[OUT_LINES-1:0] = out_mask;
    rd_mux                 = '0;
    if (in_mem) rd_mux = mem[mem_idx];
    else begin
      case (bus.BUS_ADD)
        A_START:   rd_mux = {7'b0, CMD_READY};
        A_CONF:    rd_mux = {5'b0, conf};
        A_SIZE_LO: rd_mux = cmd_size[7:0];
        A_SIZE_HI: rd_mux = cmd_size[15:8];
        A_REP_LO:  rd_mux = rep_count[7:0];
        A_REP_HI:  rd_mux = rep_count[15:8];
        A_GAP_LO:  rd_mux = rep_gap[7:0];
        A_GAP_HI:  rd_mux = rep_gap[15:8];
        A_MASK:    rd_mux = mask_rd;
        default:   rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst_all)         bus.BUS_DATA_OUT <= '0;
    else if (bus.BUS_RD) bus.BUS_DATA_OUT <= rd_mux;
  end

  assign cfg = '{size: cmd_size, rep: rep_count, gap: rep_gap};

  cmd_seq_ser #(.MEM_BYTES(MEM_BYTES), .OUT_LINES(OUT_LINES)) u_ser (
    .clk        (BUS_CLK),
    .rst        (rst_all),
    .start      (start),
    .abort      (abort),
    .cfg        (cfg),
    .mask       (out_mask),
    .mem_addr   (ser_addr),
    .mem_byte   (ser_byte),
    .cmd_data   (CMD_DATA),
    .ready      (CMD_READY),
    .rep_strobe (CMD_REP_STROBE)
  );
endmodule

// File: doc/cmd_seq_mc.md
CMD_SEQ_MC -- requirements
Module: cmd_seq_mc

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 2048, command memory depth in bytes (power of two, 16..2048).
REQ-002 SHALL have parameter OUT_LINES, default 4, number of serial command outputs (1..8).
REQ-003 SHALL have port BUS_CLK  in  1  single clock for bus, memory and serializer.
REQ-004 SHALL have port BUS_RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports BUS_ADD in 16, BUS_DATA_IN in 8, BUS_RD in 1, BUS_WR in 1: the bus address, write data, read strobe and write strobe.
REQ-006 SHALL have port BUS_DATA_OUT  out  8  registered read data.
REQ-007 SHALL have port CMD_EXT_START  in  1  external trigger, asynchronous, 2-flop synchronised internally.
REQ-008 SHALL have port CMD_DATA  out  OUT_LINES  serial command bit per line, registered.
REQ-009 SHALL have ports CMD_READY out 1 (high in IDLE) and CMD_REP_STROBE out 1 (one-cycle pulse on the first bit of each repetition).

Function
REQ-010 Register map SHALL be: 0 soft reset on any write; 1 start on write, read {7'b0,READY}; 2 CONF {5'b0, ABORT_EN, EXT_NEGEDGE, EXT_START_EN}; 3-4 CMD_SIZE bits (LSB first); 5-6 REPEAT_COUNT; 7-8 REPEAT_GAP cycles; 9 OUT_MASK[OUT_LINES-1:0]; 10 abort on any write; 11-15 read 0; addresses 16..16+MEM_BYTES-1 map to command memory byte (ADD-16).
REQ-011 Register reset values SHALL be CONF=0, CMD_SIZE=0, REPEAT_COUNT=1, REPEAT_GAP=0, OUT_MASK=all ones.
REQ-012 BUS_DATA_OUT SHALL present data of the address sampled in the previous cycle (1-cycle latency); out-of-range addresses SHALL read 0.
REQ-013 FSM states SHALL be IDLE, SEND, GAP; reset state IDLE.
REQ-014 IDLE->SEND when a start is accepted (write to addr 1, or synchronised CMD_EXT_START edge with EXT_START_EN=1; polarity per EXT_NEGEDGE) and the latched CMD_SIZE != 0; a start with CMD_SIZE=0 SHALL be ignored.
REQ-015 At start acceptance CMD_SIZE, REPEAT_COUNT, REPEAT_GAP and OUT_MASK SHALL be latched; register writes during SEND/GAP SHALL not affect the running sequence.
REQ-016 CMD_SIZE above MEM_BYTES*8 SHALL saturate to MEM_BYTES*8.
REQ-017 Bits SHALL be sent MSB first from byte 0, one bit per cycle; first bit SHALL appear on CMD_DATA 2 cycles after the start-accept cycle.
REQ-018 CMD_DATA[i] SHALL equal the current bit AND latched OUT_MASK[i]; all lines SHALL be 0 outside SEND.
REQ-019 After the last bit of a repetition: if repetitions done == REPEAT_COUNT -> IDLE; else REPEAT_GAP>0 -> GAP for exactly REPEAT_GAP cycles of 0 output, then SEND; else next repetition's first bit follows back-to-back.
REQ-020 REPEAT_COUNT=0 SHALL mean repeat indefinitely until abort or reset.
REQ-021 Starts arriving in SEND or GAP SHALL be ignored.
REQ-022 Abort (write to addr 10, or external edge while ABORT_EN=1 and busy) SHALL force IDLE next cycle with CMD_DATA=0.
REQ-023 CMD_READY SHALL be combinationally equal to (state==IDLE); it SHALL fall in the cycle after start acceptance.
REQ-024 Memory writes during SEND SHALL be accepted; resulting output content is software responsibility.

Reset
REQ-025 BUS_RST or soft reset SHALL, at the next clock edge, return state to IDLE, registers to REQ-011 values, CMD_DATA=0, CMD_REP_STROBE=0, CMD_READY=1, BUS_DATA_OUT=0; memory contents SHALL be preserved.
REQ-026 Reset mid-SEND SHALL truncate output without emitting further bits.

Structure
REQ-027 Register addresses, FSM state encoding and the memory base offset (16) SHALL live in shared package cmd_seq_pkg.
REQ-028 One sub-module cmd_seq_ser SHALL hold the bit counter, repetition/gap counters, FSM and shift register; the top holds registers, memory and bus decode.

Verification
REQ-029 Mem[0]=8'hA5, CMD_SIZE=8, REPEAT=1, start -> CMD_DATA[0] = 1,0,1,0,0,1,0,1 from cycle T+2; READY low 8 cycles then high.
REQ-030 CMD_SIZE=4, REPEAT=3, GAP=2, mem[0]=8'hF0 -> 1111 00 1111 00 1111; CMD_REP_STROBE pulses 3 times.
REQ-031 OUT_MASK=4'b0101, 8'hFF, CMD_SIZE=8 -> lines 0,2 high 8 cycles, lines 1,3 stay 0.
REQ-032 REPEAT=0, CMD_SIZE=3, abort written after 20 cycles -> output 0 and READY=1 by the following cycle.
REQ-033 EXT_START_EN=1, EXT_NEGEDGE=1, falling edge on CMD_EXT_START -> sequence starts; rising edge ignored; second edge while busy ignored.
REQ-034 BUS_RST mid-SEND -> CMD_DATA=0 next cycle, registers read defaults, previously written mem[0] reads back unchanged.
